// File: rtl/noc_pkg.sv
// noc_pkg: flit type codes, default flit width and arbiter state encoding shared by the port arbiter
package noc_pkg;
  localparam int FLIT_W = 11;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  function automatic logic starts_pkt(input logic [1:0] t);
    return t == FLIT_HEAD || t == FLIT_SINGLE;
  endfunction
endpackage

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: combinational round-robin picker, first requester after ptr wins (wrapping)
//   req  in  N   request vector
//   ptr  in  IW  last winner
//   gnt  out N   one-hot grant
//   idx  out IW  index of winner
//   any  out 1   some requester won
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int c;
    c   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[IW'(c)]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: wormhole output-port arbiter with round-robin head grant and credit flow control
//   clock, reset(sync active-low)
//   req_valid/req_flit/req_ready  per-requester flit handshake, requester i at [i*FLIT_W +: FLIT_W]
//   out_valid/out_flit            registered outgoing flit, one cycle after acceptance
//   credit_return                 downstream freed a buffer slot
//   grant_id/busy                 current or last link owner, packet in progress
//   NOC_ARB_STATS_EN adds pkt_cnt (16b per requester, completed packets) and credit_err (sticky)
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int FLIT_W     = noc_pkg::FLIT_W,
  parameter  int CREDIT_MAX = 4,
  localparam int GW         = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  input  logic                      credit_return,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     pkt_cnt,
  output logic                      credit_err
`endif
);
  state_t              state_q, state_d;
  logic [GW-1:0]       rr_ptr, pick_idx, sel;
  logic [CW-1:0]       credits;
  logic [NUM_REQ-1:0]  cand, pick_gnt;
  logic                pick_any, xfer;
  logic [FLIT_W-1:0]   sel_flit;
  logic [1:0]          sel_type;
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      cand[i] = req_valid[i] && starts_pkt(req_flit[i*FLIT_W+FLIT_W-2 +: 2]);
  end
  noc_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(cand),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    req_ready = credits == '0 ? '0 :
                state_q == ST_IDLE ? pick_gnt :
                req_valid[grant_id] ? NUM_REQ'(1) << grant_id : '0;
    xfer     = |req_ready;
    sel      = state_q == ST_IDLE ? pick_idx : grant_id;
    sel_flit = req_flit[int'(sel)*FLIT_W +: FLIT_W];
    sel_type = sel_flit[FLIT_W-1 -: 2];
    state_d  = state_q == ST_IDLE ? (xfer && sel_type == FLIT_HEAD ? ST_LOCKED : ST_IDLE) :
               (xfer && sel_type == FLIT_TAIL ? ST_IDLE : ST_LOCKED);
  end
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
  // simultaneous transfer and credit return cancel out; returns beyond CREDIT_MAX are dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      grant_id  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      credits   <= CW'(CREDIT_MAX);
    end else begin
      out_valid <= xfer;
      if (xfer) out_flit <= sel_flit;
      if (xfer && state_q == ST_IDLE) begin
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
      end
      if (xfer && !credit_return) credits <= credits - CW'(1);
      else if (!xfer && credit_return && credits != CW'(CREDIT_MAX)) credits <= credits + CW'(1);
    end
  end
  assign busy = state_q == ST_LOCKED;
`ifdef NOC_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];
  // type bit 1 set means TAIL or SINGLE, i.e. a packet just completed
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      credit_err <= 1'b0;
    end else begin
      if (xfer && sel_type[1]) cnt[sel] <= cnt[sel] + 16'd1;
      if (credit_return && credits == CW'(CREDIT_MAX)) credit_err <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pk
    assign pkt_cnt[g*16 +: 16] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed and random checks of the port arbiter against a packet-level model
module tb_noc_port_arbiter;
  import noc_pkg::*;
  localparam int N = 4, FW = 11, CM = 4;
  logic            clock = 1'b0, reset = 1'b0, credit_return = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*FW-1:0] req_flit = '0;
  logic            out_valid, busy;
  logic [FW-1:0]   out_flit, exp_flit;
  logic [1:0]      grant_id;
  int              vectors = 0, miscompares = 0, w, pulses;
  bit              m_locked, exp_valid;
  int              m_owner, m_rr, m_cred;
`ifdef NOC_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic            credit_err;
  int              m_cnt [N];
  bit              m_err;
`endif
  always #5 clock = ~clock;
  noc_port_arbiter #(.NUM_REQ(N), .FLIT_W(FW), .CREDIT_MAX(CM)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(req_ready), .out_valid(out_valid), .out_flit(out_flit),
    .credit_return(credit_return), .grant_id(grant_id), .busy(busy)
`ifdef NOC_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt), .credit_err(credit_err)
`endif
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] typ(int i);
    return req_flit[i*FW+FW-2 +: 2];
  endfunction
  task automatic set_req(int i, logic v, logic [1:0] t);
    req_valid[i] = v;
    req_flit[i*FW +: FW] = {t, 9'($urandom)};
  endtask
  function automatic int pick();
    if (m_cred == 0) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_rr + k) % N;
      if (req_valid[c] && (typ(c) == FLIT_HEAD || typ(c) == FLIT_SINGLE)) return c;
    end
    return -1;
  endfunction
  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = N - 1; m_cred = CM; exp_valid = 0; exp_flit = '0;
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_err = 0;
`endif
  endtask
  task automatic chk_stats();
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("pkt_cnt", 32'(pkt_cnt[i*16 +: 16]), 32'(m_cnt[i] % 65536));
    chk("credit_err", 32'(credit_err), 32'(m_err));
`endif
  endtask
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_flit", 32'(out_flit), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_stats();
  endtask
  task automatic step(output int acc);
    logic [1:0] t;
    #1;
    acc = pick();
    chk("req_ready", 32'(req_ready), acc >= 0 ? 32'(1) << acc : 32'd0);
    @(posedge clock);
    if (acc >= 0) begin
      t = typ(acc);
      exp_flit = req_flit[acc*FW +: FW];
      if (!m_locked) begin
        m_owner = acc; m_rr = acc; m_locked = (t == FLIT_HEAD);
      end else if (t == FLIT_TAIL) m_locked = 0;
`ifdef NOC_ARB_STATS_EN
      if (t == FLIT_TAIL || t == FLIT_SINGLE) m_cnt[acc]++;
`endif
    end
`ifdef NOC_ARB_STATS_EN
    if (credit_return && m_cred == CM) m_err = 1;
`endif
    m_cred += (acc >= 0 ? -1 : 0) + (credit_return ? 1 : 0);
    if (m_cred > CM) m_cred = CM;
    exp_valid = (acc >= 0);
    @(negedge clock);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) chk("out_flit", 32'(out_flit), 32'(exp_flit));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_locked));
    chk_stats();
  endtask
  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    // all SINGLE, credits replenished every cycle: strict rotation 0,1,2,3,0
    credit_return = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, FLIT_SINGLE);
    for (int k = 0; k < 5; k++) begin
      step(w);
      chk("t1_grant", 32'(grant_id), 32'(k % N));
      chk("t1_valid", 32'(out_valid), 1);
    end
    // req0 packet holds the link while req1 waits with a HEAD
    req_valid = '0;
    do_reset();
    credit_return = 1'b1;
    set_req(0, 1'b1, FLIT_HEAD);
    set_req(1, 1'b1, FLIT_HEAD);
    step(w);
    chk("t2_busy_head", 32'(busy), 1);
    set_req(0, 1'b1, FLIT_BODY);
    step(w);
    step(w);
    chk("t2_busy_body", 32'(busy), 1);
    set_req(0, 1'b1, FLIT_TAIL);
    step(w);
    chk("t2_busy_tail", 32'(busy), 0);
    set_req(0, 1'b0, FLIT_BODY);
    step(w);
    chk("t2_req1_won", 32'(w), 1);
    chk("t2_grant", 32'(grant_id), 1);
    // credit exhaustion and recovery
    req_valid = '0;
    do_reset();
    credit_return = 1'b0;
    set_req(0, 1'b1, FLIT_HEAD);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(w);
      if (out_valid) pulses++;
      set_req(0, 1'b1, FLIT_BODY);
    end
    chk("t3_pulses", 32'(pulses), 4);
    credit_return = 1'b1;
    step(w);
    chk("t3_no_xfer_on_return", 32'(out_valid), 0);
    credit_return = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(w);
      if (out_valid) pulses++;
    end
    chk("t3_one_more", 32'(pulses), 1);
    credit_return = 1'b1;
    step(w);
    step(w);
    credit_return = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(w);
      if (out_valid) pulses++;
    end
    chk("t3_return_plus_xfer", 32'(pulses), 1);
    // BODY offered in IDLE is never taken
    req_valid = '0;
    do_reset();
    set_req(2, 1'b1, FLIT_BODY);
    for (int k = 0; k < 4; k++) begin
      step(w);
      chk("t4_out_valid", 32'(out_valid), 0);
      chk("t4_grant", 32'(grant_id), 0);
    end
    // reset in the middle of a packet
    req_valid = '0;
    do_reset();
    set_req(2, 1'b1, FLIT_HEAD);
    step(w);
    set_req(2, 1'b1, FLIT_BODY);
    step(w);
    chk("t5_locked", 32'(busy), 1);
    do_reset();
    set_req(2, 1'b0, FLIT_BODY);
    set_req(0, 1'b1, FLIT_HEAD);
    set_req(3, 1'b1, FLIT_HEAD);
    step(w);
    chk("t5_req0_wins", 32'(grant_id), 0);
    set_req(0, 1'b1, FLIT_BODY);
    for (int k = 0; k < 4; k++) step(w);
    chk("t5_full_credits", 32'(m_cred), 0);
`ifdef NOC_ARB_STATS_EN
    req_valid = '0;
    do_reset();
    credit_return = 1'b1;
    set_req(1, 1'b1, FLIT_HEAD); step(w);
    set_req(1, 1'b1, FLIT_TAIL); step(w);
    set_req(1, 1'b1, FLIT_SINGLE); step(w);
    set_req(1, 1'b0, FLIT_BODY);
    set_req(3, 1'b1, FLIT_SINGLE); step(w);
    set_req(3, 1'b0, FLIT_BODY); step(w);
    chk("t6_cnt1", 32'(pkt_cnt[16 +: 16]), 2);
    chk("t6_cnt3", 32'(pkt_cnt[48 +: 16]), 1);
    chk("t6_err", 32'(credit_err), 1);
    credit_return = 1'b0;
    step(w);
    chk("t6_err_sticky", 32'(credit_err), 1);
    do_reset();
`endif
    // randomized traffic
    req_valid = '0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 2'($urandom));
      credit_return = ($urandom % 10) < 4;
      step(w);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
